// File: rtl/adf4158_pkg.sv
// Shared types and constants for the ADF4158 configuration controller.
package adf4158_pkg;

    localparam int NUM_REGS  = 8;
    localparam int WORD_W    = 32;
    localparam int SHIFT_CYC = 2;
    localparam int LATCH_CYC = 2;
    localparam int GAP_CYC   = 2;

    // Clock cycles spent on one register word: serial bits, latch pulse, gap.
    localparam int CYC_PER_WORD = WORD_W * SHIFT_CYC + LATCH_CYC + GAP_CYC;

    typedef enum logic [2:0] {
        IDLE,
        CE_WAIT,
        SHIFT,
        LATCH,
        GAP,
        LOCK_WAIT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_LATCH,
        SPI_GAP
    } spi_state_e;

    // Select one register word out of the packed register bank (index 0 = R0).
    function automatic logic [WORD_W-1:0] pick_word(
        input logic [NUM_REGS-1:0][WORD_W-1:0] regs,
        input logic [2:0]                      idx
    );
        return regs[idx];
    endfunction

endpackage

// File: rtl/adf4158_spi_tx.sv
// 32-bit MSB-first serializer for the ADF4158 three-wire interface.
// Each bit uses two clocks (sclk low with data, then sclk high), followed by
// a two-cycle LE pulse and a two-cycle quiet gap. A new word may be loaded in
// the final gap cycle so consecutive words run back to back.
module adf4158_spi_tx
    import adf4158_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              busy_o,
    output logic              shift_last_o,
    output logic              latch_last_o,
    output logic              gap_last_o,
    output logic              sclk_o,
    output logic              data_o,
    output logic              le_o
);

    localparam logic [1:0] LATCH_LAST = 2'(LATCH_CYC - 1);
    localparam logic [1:0] GAP_LAST   = 2'(GAP_CYC - 1);
    localparam logic [4:0] BIT_MSB    = 5'(WORD_W - 1);

    spi_state_e        st_q, st_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [4:0]        bit_q, bit_d;
    logic              ph_q, ph_d;      // 0: sclk-low half, 1: sclk-high half
    logic [1:0]        cnt_q, cnt_d;
    logic              sclk_q, sclk_d;
    logic              data_q, data_d;
    logic              le_q, le_d;

    assign busy_o       = (st_q != SPI_IDLE);
    assign shift_last_o = (st_q == SPI_SHIFT) && ph_q && (bit_q == 5'd0);
    assign latch_last_o = (st_q == SPI_LATCH) && (cnt_q == LATCH_LAST);
    assign gap_last_o   = (st_q == SPI_GAP) && (cnt_q == GAP_LAST);

    assign sclk_o = sclk_q;
    assign data_o = data_q;
    assign le_o   = le_q;

    // Next-state logic for the bit/latch/gap sequencer and its registered pins.
    always_comb begin
        st_d   = st_q;
        sreg_d = sreg_q;
        bit_d  = bit_q;
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        data_d = data_q;
        le_d   = le_q;
        case (st_q)
            SPI_IDLE: begin
                sclk_d = 1'b0;
                data_d = 1'b0;
                le_d   = 1'b0;
            end
            SPI_SHIFT: begin
                if (!ph_q) begin
                    sclk_d = 1'b1;
                    ph_d   = 1'b1;
                end else if (bit_q == 5'd0) begin
                    st_d   = SPI_LATCH;
                    sclk_d = 1'b0;
                    data_d = 1'b0;
                    le_d   = 1'b1;
                    cnt_d  = 2'd0;
                end else begin
                    sclk_d = 1'b0;
                    ph_d   = 1'b0;
                    bit_d  = bit_q - 5'd1;
                    sreg_d = sreg_q << 1;
                    data_d = sreg_q[WORD_W-2];
                end
            end
            SPI_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    st_d  = SPI_GAP;
                    le_d  = 1'b0;
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            SPI_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    st_d  = SPI_IDLE;
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: st_d = SPI_IDLE;
        endcase
        // A load starts the first sclk-low half with the MSB already on data.
        if (load_i && ((st_q == SPI_IDLE) || gap_last_o)) begin
            st_d   = SPI_SHIFT;
            sreg_d = word_i;
            bit_d  = BIT_MSB;
            ph_d   = 1'b0;
            cnt_d  = 2'd0;
            sclk_d = 1'b0;
            data_d = word_i[WORD_W-1];
            le_d   = 1'b0;
        end
    end

    // State and output registers; reset or abort returns everything to idle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            st_q   <= SPI_IDLE;
            sreg_q <= '0;
            bit_q  <= '0;
            ph_q   <= 1'b0;
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            data_q <= 1'b0;
            le_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            sreg_q <= sreg_d;
            bit_q  <= bit_d;
            ph_q   <= ph_d;
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
            data_q <= data_d;
            le_q   <= le_d;
        end
    end

endmodule

// File: rtl/adf4158.sv
// ADF4158 configuration controller: powers the chip up, writes R7..R0 over
// the serial interface, then waits for a stable digital lock indication on
// MUXOUT before reporting config_done.
module adf4158
    import adf4158_pkg::*;
#(
    parameter logic [31:0] R0          = 32'h0000_0000,
    parameter logic [31:0] R1          = 32'h0000_0001,
    parameter logic [31:0] R2          = 32'h0000_0002,
    parameter logic [31:0] R3          = 32'h0000_0003,
    parameter logic [31:0] R4          = 32'h0000_0004,
    parameter logic [31:0] R5          = 32'h0000_0005,
    parameter logic [31:0] R6          = 32'h0000_0006,
    parameter logic [31:0] R7          = 32'h0000_0007,
    parameter int          CE_SETTLE   = 16,
    parameter int          LOCK_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic muxout,
    output logic ce,
    output logic le,
    output logic sclk,
    output logic data,
    output logic txdata,
    output logic config_done
);

    localparam logic [NUM_REGS-1:0][WORD_W-1:0] REGS = {R7, R6, R5, R4, R3, R2, R1, R0};
    localparam logic [15:0] CE_LAST   = 16'(CE_SETTLE - 1);
    localparam logic [15:0] LOCK_FULL = 16'(LOCK_CYCLES);

    state_e      state_q;
    logic [15:0] ce_cnt_q;
    logic [2:0]  reg_idx_q;
    logic [15:0] lock_cnt_q;
    logic        sync1_q, sync2_q;
    logic        ce_q;
    logic        done_q;

    logic              spi_load;
    logic [2:0]        load_idx;
    logic [WORD_W-1:0] spi_word;
    logic              spi_busy;
    logic              spi_shift_last;
    logic              spi_latch_last;
    logic              spi_gap_last;

    // The first word loads once the serializer is idle in SHIFT; every later
    // word loads in the previous word's last gap cycle to keep 68-cycle pacing.
    assign spi_load = enable &&
                      (((state_q == SHIFT) && !spi_busy) ||
                       ((state_q == GAP) && spi_gap_last && (reg_idx_q != 3'd0)));
    assign load_idx = (state_q == GAP) ? (reg_idx_q - 3'd1) : reg_idx_q;
    assign spi_word = pick_word(REGS, load_idx);

    adf4158_spi_tx u_spi_tx (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (!enable),
        .load_i       (spi_load),
        .word_i       (spi_word),
        .busy_o       (spi_busy),
        .shift_last_o (spi_shift_last),
        .latch_last_o (spi_latch_last),
        .gap_last_o   (spi_gap_last),
        .sclk_o       (sclk),
        .data_o       (data),
        .le_o         (le)
    );

    assign ce          = ce_q;
    assign config_done = done_q;
    assign txdata      = 1'b0;   // ramp free-runs from the R3 setting

    // MUXOUT synchronizer, armed only after programming so that a lock
    // indication left over from an earlier configuration is never counted.
    always_ff @(posedge clk) begin
        if (rst || !((state_q == LOCK_WAIT) || (state_q == DONE))) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= muxout;
            sync2_q <= sync1_q;
        end
    end

    // Configuration sequencer: power-up settle, register writes, lock wait.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state_q    <= IDLE;
            ce_cnt_q   <= '0;
            reg_idx_q  <= '0;
            lock_cnt_q <= '0;
            ce_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= CE_WAIT;
                    ce_q     <= 1'b1;
                    ce_cnt_q <= '0;
                end
                CE_WAIT: begin
                    if (ce_cnt_q == CE_LAST) begin
                        state_q   <= SHIFT;
                        reg_idx_q <= 3'(NUM_REGS - 1);
                    end else begin
                        ce_cnt_q <= ce_cnt_q + 16'd1;
                    end
                end
                SHIFT: begin
                    if (spi_shift_last) state_q <= LATCH;
                end
                LATCH: begin
                    if (spi_latch_last) state_q <= GAP;
                end
                GAP: begin
                    if (spi_gap_last) begin
                        if (reg_idx_q == 3'd0) begin
                            state_q    <= LOCK_WAIT;
                            lock_cnt_q <= '0;
                        end else begin
                            state_q   <= SHIFT;
                            reg_idx_q <= reg_idx_q - 3'd1;
                        end
                    end
                end
                LOCK_WAIT: begin
                    if (lock_cnt_q == LOCK_FULL) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (sync2_q) begin
                        lock_cnt_q <= lock_cnt_q + 16'd1;
                    end else begin
                        lock_cnt_q <= '0;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ce_q    <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adf4158.sv
// Directed testbench for the ADF4158 configuration controller.
module tb_adf4158;

    logic clk = 1'b0;
    logic rst, enable, muxout;
    logic ce, le, sclk, data, txdata, config_done;

    int checks   = 0;
    int failures = 0;

    // Capture results (written only by the capture task)
    int          n, ce_rise, first_sclk, le_pulses, le_bad, last_le_fall, done_at, viol;
    int          bits;
    bit          aborted;
    logic [31:0] cur_word;
    logic [31:0] words[$];

    adf4158 #(
        .R0(32'hA5A5_0000), .R1(32'hA5A5_0001), .R2(32'hA5A5_0002), .R3(32'hA5A5_0003),
        .R4(32'hA5A5_0004), .R5(32'hA5A5_0005), .R6(32'hA5A5_0006), .R7(32'hA5A5_0007),
        .CE_SETTLE(16), .LOCK_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .muxout(muxout),
        .ce(ce), .le(le), .sclk(sclk), .data(data), .txdata(txdata),
        .config_done(config_done)
    );

    always #5 clk = ~clk;

    // Observe the serial pins cycle by cycle (n = posedges since the call).
    task automatic capture(input int max_cyc, input bit glitch, input int abort_words);
        logic p_ce, p_sclk, p_le;
        int   le_w;
        n = 0; ce_rise = -1; first_sclk = -1; le_pulses = 0; le_bad = 0;
        last_le_fall = -1; done_at = -1; viol = 0; bits = 0; aborted = 0;
        cur_word = '0; words.delete();
        p_ce = ce; p_sclk = sclk; p_le = le; le_w = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            n++;
            if (ce && !p_ce && ce_rise < 0) ce_rise = n;
            if (sclk && !p_sclk) begin
                if (first_sclk < 0) first_sclk = n;
                cur_word = {cur_word[30:0], data};
                bits++;
                if (bits == 32) begin
                    words.push_back(cur_word);
                    bits = 0;
                end
            end
            if (le) le_w++;
            else if (p_le) begin
                le_pulses++;
                if (le_w != 2) le_bad++;
                le_w = 0;
                last_le_fall = n;
            end
            if (sclk && le) viol++;
            if (txdata) viol++;
            if (glitch && le_pulses == 8 && n == last_le_fall + 44) muxout = 1'b0;
            if (glitch && le_pulses == 8 && n == last_le_fall + 45) muxout = 1'b1;
            p_ce = ce; p_sclk = sclk; p_le = le;
            if (abort_words >= 0 && words.size() == abort_words && bits == 10) begin
                aborted = 1'b1;
                break;
            end
            if (config_done) begin
                done_at = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; muxout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ce, le, sclk, data, txdata, config_done} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs: got %b expected 000000",
                         {ce, le, sclk, data, txdata, config_done});
            end
        end
        rst = 1'b0; enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_serial_lock();
        logic [31:0] got, exp;
        enable = 1'b1; muxout = 1'b1;
        capture(2000, 1'b0, -1);
        checks++;
        if (ce_rise !== 1) begin
            failures++; $display("FAIL ce_rise: got %0d expected 1", ce_rise);
        end
        checks++;
        if (first_sclk - ce_rise !== 18) begin
            failures++; $display("FAIL first_sclk_delay: got %0d expected 18", first_sclk - ce_rise);
        end
        checks++;
        if (words.size() !== 8) begin
            failures++; $display("FAIL word_count: got %0d expected 8", words.size());
        end
        for (int k = 0; k < 8; k++) begin
            got = (k < words.size()) ? words[k] : 32'hxxxx_xxxx;
            exp = 32'hA5A5_0000 | 32'(7 - k);
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL word_%0d: got %h expected %h", k, got, exp);
            end
        end
        checks++;
        if (le_pulses !== 8 || le_bad !== 0) begin
            failures++; $display("FAIL le_pulses: got %0d (bad width %0d) expected 8 (0)", le_pulses, le_bad);
        end
        checks++;
        if (last_le_fall !== 560) begin
            failures++; $display("FAIL last_le_fall: got %0d expected 560", last_le_fall);
        end
        checks++;
        if (viol !== 0) begin
            failures++; $display("FAIL pin_rules: got %0d violations expected 0", viol);
        end
        checks++;
        if (done_at - (last_le_fall + 2) !== 67) begin
            failures++; $display("FAIL lock_latency: got %0d expected 67", done_at - (last_le_fall + 2));
        end
        // Lock loss after DONE must not drop config_done.
        muxout = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (config_done !== 1'b1 || ce !== 1'b1) begin
            failures++; $display("FAIL done_hold: got %b%b expected 11", config_done, ce);
        end
        muxout = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({ce, le, sclk, data, config_done} !== 5'b0) begin
            failures++; $display("FAIL disable_from_done: got %b expected 00000",
                                 {ce, le, sclk, data, config_done});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock_glitch();
        enable = 1'b1; muxout = 1'b1;
        capture(2000, 1'b1, -1);
        checks++;
        if (words.size() !== 8) begin
            failures++; $display("FAIL glitch_word_count: got %0d expected 8", words.size());
        end
        checks++;
        if (done_at - (last_le_fall + 2) !== 110) begin
            failures++; $display("FAIL glitch_lock_latency: got %0d expected 110",
                                 done_at - (last_le_fall + 2));
        end
        enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        logic [31:0] got;
        enable = 1'b1; muxout = 1'b1;
        capture(2000, 1'b0, 3);
        checks++;
        if (!aborted || words.size() !== 3) begin
            failures++; $display("FAIL abort_point: got aborted=%0d words=%0d expected 1 3",
                                 aborted, words.size());
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({ce, sclk, le, data, config_done} !== 5'b0) begin
            failures++; $display("FAIL abort_outputs: got %b expected 00000",
                                 {ce, sclk, le, data, config_done});
        end
        repeat (3) @(negedge clk);
        enable = 1'b1;
        capture(2000, 1'b0, -1);
        got = (words.size() > 0) ? words[0] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'hA5A5_0007) begin
            failures++; $display("FAIL reenable_first_word: got %h expected a5a50007", got);
        end
        checks++;
        if (words.size() !== 8 || done_at !== 629) begin
            failures++; $display("FAIL reenable_full: got words=%0d done_at=%0d expected 8 629",
                                 words.size(), done_at);
        end
    endtask

    task automatic test_reset_in_done();
        logic [31:0] got;
        checks++;
        if (config_done !== 1'b1) begin
            failures++; $display("FAIL pre_reset_done: got %b expected 1", config_done);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (config_done !== 1'b0 || ce !== 1'b0) begin
            failures++; $display("FAIL reset_in_done: got done=%b ce=%b expected 0 0", config_done, ce);
        end
        rst = 1'b0;
        capture(2000, 1'b0, -1);
        got = (words.size() == 8) ? words[7] : 32'hxxxx_xxxx;
        checks++;
        if (got !== 32'hA5A5_0000) begin
            failures++; $display("FAIL post_reset_last_word: got %h expected a5a50000", got);
        end
        checks++;
        if (ce_rise !== 1 || done_at !== 629) begin
            failures++; $display("FAIL post_reset_sequence: got ce_rise=%0d done_at=%0d expected 1 629",
                                 ce_rise, done_at);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; muxout = 1'b0;
        test_reset();
        test_serial_lock();
        test_lock_glitch();
        test_abort();
        test_reset_in_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
